// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - decoder and instruction-memory signal bundle for fetch_unit
interface fetch_unit_if;
    // decoder -> fetch
    logic        pc_enable;
    logic        pc_src;
    logic        br_src;
    logic [1:0]  br_cond;
    logic        nz_we;
    logic        busy;
    logic [15:0] alu_result;
    logic [15:0] rx_data;
    logic [15:0] imm_ext;
    // instruction memory -> fetch
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    // fetch -> instruction memory
    logic        mem_rd;
    logic [15:0] mem_addr;
    // fetch -> decoder
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        flag_n;
    logic        flag_z;
    logic        instr_valid;

    modport master (
        input  pc_enable, pc_src, br_src, br_cond, nz_we, busy,
        input  alu_result, rx_data, imm_ext, mem_rdata, mem_rvalid,
        output mem_rd, mem_addr, instr, opcode, pc, pc_plus2,
        output flag_n, flag_z, instr_valid
    );

    modport slave (
        output pc_enable, pc_src, br_src, br_cond, nz_we, busy,
        output alu_result, rx_data, imm_ext, mem_rdata, mem_rvalid,
        input  mem_rd, mem_addr, instr, opcode, pc, pc_plus2,
        input  flag_n, flag_z, instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer with PC, branch resolution and N/Z flags
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    // Instructions are halfword aligned, so the reset PC is forced even.
    localparam logic [15:0] PC_INIT = {RESET_PC[15:1], 1'b0};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_EXEC = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_load_instr;
    logic        w_retire;
    logic        w_mem_rd;
    logic        w_instr_valid;

    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic        r_flag_n;
    logic        r_flag_z;

    logic        w_cond_ok;
    logic        w_taken;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_rel_target;
    logic [15:0] w_target;
    logic [15:0] w_next_pc;

    // State register; reset abandons any outstanding memory request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobes: read data is only accepted in WAIT, the PC only moves when EXEC is released.
    always_comb begin
        w_next_state  = r_state;
        w_load_instr  = 1'b0;
        w_retire      = 1'b0;
        w_mem_rd      = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_REQ;
            end
            S_REQ: begin
                w_mem_rd     = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_load_instr = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_instr_valid = 1'b1;
                if (!bus.busy) begin
                    w_retire     = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Branch condition evaluated against the flags as they stood before this instruction's update.
    always_comb begin
        w_cond_ok = 1'b0;
        case (bus.br_cond)
            2'b00:   w_cond_ok = 1'b1;
            2'b01:   w_cond_ok = r_flag_z;
            2'b10:   w_cond_ok = r_flag_n;
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign w_taken      = bus.pc_enable & ~bus.pc_src & w_cond_ok;
    assign w_pc_plus2   = r_pc + 16'd2;
    assign w_rel_target = w_pc_plus2 + {bus.imm_ext[14:0], 1'b0};
    assign w_target     = bus.br_src ? w_rel_target : {bus.rx_data[15:1], 1'b0};
    assign w_next_pc    = w_taken ? w_target : w_pc_plus2;

    // Architectural registers: instruction capture on read data, PC and flags on instruction retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= PC_INIT;
            r_instr  <= 16'h0000;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            if (w_load_instr) begin
                r_instr <= bus.mem_rdata;
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
                if (bus.nz_we) begin
                    r_flag_n <= bus.alu_result[15];
                    r_flag_z <= (bus.alu_result == 16'h0000);
                end
            end
        end
    end

    assign bus.mem_rd      = w_mem_rd;
    assign bus.mem_addr    = r_pc;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[4:0];
    assign bus.pc          = r_pc;
    assign bus.pc_plus2    = w_pc_plus2;
    assign bus.flag_n      = r_flag_n;
    assign bus.flag_z      = r_flag_z;
    assign bus.instr_valid = w_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural fetch/branch model
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference architectural state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic        m_n;
    logic        m_z;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " pc"},       bus.pc,       m_pc);
        chk({tag, " pc_plus2"}, bus.pc_plus2, m_pc + 16'd2);
        chk({tag, " instr"},    bus.instr,    m_instr);
        chk({tag, " opcode"},   {11'd0, bus.opcode}, {11'd0, m_instr[4:0]});
        chk({tag, " flag_n"},   {15'd0, bus.flag_n}, {15'd0, m_n});
        chk({tag, " flag_z"},   {15'd0, bus.flag_z}, {15'd0, m_z});
    endtask

    // Random values on every input the DUT should be ignoring at this point
    task automatic set_junk();
        bus.pc_enable  = 1'($urandom_range(0, 1));
        bus.pc_src     = 1'($urandom_range(0, 1));
        bus.br_src     = 1'($urandom_range(0, 1));
        bus.br_cond    = 2'($urandom_range(0, 3));
        bus.nz_we      = 1'($urandom_range(0, 1));
        bus.busy       = 1'($urandom_range(0, 1));
        bus.alu_result = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
        bus.rx_data    = 16'($urandom);
        bus.imm_ext    = 16'($urandom);
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata  = 16'($urandom);
    endtask

    // Called at a negedge; asynchronous assertion is checked before any clock edge
    task automatic assert_reset();
        reset = 1'b1;
        #1;
        m_pc    = RESET_PC;
        m_instr = 16'h0000;
        m_n     = 1'b0;
        m_z     = 1'b0;
        chk("reset mem_rd",      {15'd0, bus.mem_rd},      16'h0000);
        chk("reset instr_valid", {15'd0, bus.instr_valid}, 16'h0000);
        check_state("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_junk();
        #1;
        chk("idle mem_rd",      {15'd0, bus.mem_rd},      16'h0000);
        chk("idle instr_valid", {15'd0, bus.instr_valid}, 16'h0000);
    endtask

    // Entered at the negedge of a REQ cycle, returns at the negedge of the EXEC cycle
    task automatic fetch(input logic [15:0] data, input int waits);
        chk("req mem_rd",      {15'd0, bus.mem_rd},      16'h0001);
        chk("req mem_addr",    bus.mem_addr,             m_pc);
        chk("req instr_valid", {15'd0, bus.instr_valid}, 16'h0000);
        set_junk();
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            chk("wait mem_rd",      {15'd0, bus.mem_rd},      16'h0000);
            chk("wait instr_valid", {15'd0, bus.instr_valid}, 16'h0000);
            chk("wait instr",       bus.instr,                m_instr);
            set_junk();
            if (i < waits) begin
                bus.mem_rvalid = 1'b0;
            end else begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = data;
            end
        end
        @(negedge clk);
        m_instr = data;
        set_junk();
        chk("exec instr_valid", {15'd0, bus.instr_valid}, 16'h0001);
        chk("exec mem_rd",      {15'd0, bus.mem_rd},      16'h0000);
        check_state("exec");
    endtask

    // Entered at the negedge of EXEC, holds busy for nbusy cycles, then retires; returns at the next REQ negedge
    task automatic exec(input logic en, input logic src, input logic bsrc, input logic [1:0] cond,
                        input logic nzwe, input logic [15:0] alu, input logic [15:0] rx,
                        input logic [15:0] imm, input int nbusy);
        logic        cond_ok;
        logic [15:0] seq;
        for (int b = 0; b < nbusy; b++) begin
            set_junk();
            bus.busy = 1'b1;
            @(negedge clk);
            chk("busy mem_rd",      {15'd0, bus.mem_rd},      16'h0000);
            chk("busy instr_valid", {15'd0, bus.instr_valid}, 16'h0001);
            check_state("busy");
        end
        set_junk();
        bus.busy       = 1'b0;
        bus.pc_enable  = en;
        bus.pc_src     = src;
        bus.br_src     = bsrc;
        bus.br_cond    = cond;
        bus.nz_we      = nzwe;
        bus.alu_result = alu;
        bus.rx_data    = rx;
        bus.imm_ext    = imm;
        @(negedge clk);
        seq = m_pc + 16'd2;
        case (cond)
            2'd0:    cond_ok = 1'b1;
            2'd1:    cond_ok = m_z;
            2'd2:    cond_ok = m_n;
            default: cond_ok = 1'b0;
        endcase
        if (en && !src && cond_ok) begin
            m_pc = bsrc ? seq + (imm << 1) : (rx & 16'hFFFE);
        end else begin
            m_pc = seq;
        end
        if (nzwe) begin
            m_n = alu[15];
            m_z = (alu == 16'h0000);
        end
        chk("retire pc",     bus.pc,              m_pc);
        chk("retire flag_n", {15'd0, bus.flag_n}, {15'd0, m_n});
        chk("retire flag_z", {15'd0, bus.flag_z}, {15'd0, m_z});
    endtask

    initial begin
        logic [15:0] r_alu;
        reset          = 1'b1;
        bus.pc_enable  = 1'b0;
        bus.pc_src     = 1'b0;
        bus.br_src     = 1'b0;
        bus.br_cond    = 2'b00;
        bus.nz_we      = 1'b0;
        bus.busy       = 1'b0;
        bus.alu_result = 16'h0000;
        bus.rx_data    = 16'h0000;
        bus.imm_ext    = 16'h0000;
        bus.mem_rdata  = 16'h0000;
        bus.mem_rvalid = 1'b0;

        // Reset, first fetch: mem_rd on cycle 1 at 0000, instr_valid on cycle 3
        @(negedge clk);
        assert_reset();
        @(negedge clk);
        fetch(16'h0001, 0);
        chk("first opcode", {11'd0, bus.opcode}, 16'h0001);

        // Sequential step, next request at 0002
        exec(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("seq pc 0002", bus.mem_addr, 16'h0002);
        fetch(16'h1A2B, 1);

        // Register jump to 0010 while setting Z
        exec(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 16'h0000, 16'h0010, 16'h0000, 0);
        fetch(16'h0C03, 0);

        // Z=1, if-Z relative by -1 word: 0010 -> 000E; Z cleared in the same cycle
        exec(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 16'h0005, 16'h0000, 16'hFFFE, 0);
        chk("rel taken pc", bus.pc, 16'h000E);
        fetch(16'h0004, 2);

        // Back to 0010 (odd register value), then Z=0 case falls through to 0012
        exec(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0011, 16'h0000, 0);
        chk("odd rx pc", bus.pc, 16'h0010);
        fetch(16'h0005, 0);
        exec(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, 0);
        chk("rel not taken pc", bus.pc, 16'h0012);
        fetch(16'h0006, 0);

        // Register target with bit 0 set
        exec(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h1235, 16'h0000, 0);
        chk("reg jump pc", bus.pc, 16'h1234);
        fetch(16'h0007, 1);

        // Busy for 3 cycles, then sequential
        exec(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3);
        chk("after busy pc", bus.pc, 16'h1236);
        fetch(16'h0008, 0);

        // nz_we sets N while if-N uses the old N=0: not taken
        exec(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 16'h8000, 16'h0000, 16'h0040, 0);
        chk("if-N old flag pc", bus.pc, 16'h1238);
        chk("flag_n set", {15'd0, bus.flag_n}, 16'h0001);
        fetch(16'h0009, 0);

        // Now N=1: if-N taken, 123A + 0020
        exec(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1);
        chk("if-N taken pc", bus.pc, 16'h125A);
        fetch(16'h000A, 0);

        // Never condition, then pc_src=1 overrides pc_enable
        exec(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 16'h0000, 16'h4000, 16'h0000, 0);
        chk("never pc", bus.pc, 16'h125C);
        fetch(16'h000B, 0);
        exec(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h4000, 16'h0000, 0);
        chk("pc_src seq pc", bus.pc, 16'h125E);
        fetch(16'h000C, 0);

        // Wrap: FFFE + 2 = 0000
        exec(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 0);
        chk("top pc", bus.pc, 16'hFFFE);
        fetch(16'h000D, 0);
        chk("top pc_plus2", bus.pc_plus2, 16'h0000);
        exec(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("wrap pc", bus.pc, 16'h0000);
        fetch(16'h000E, 0);

        // Reset while a request is outstanding; the late response is dropped
        exec(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 16'h8001, 16'h4444, 16'h0000, 0);
        chk("pre-reset req", bus.mem_addr, 16'h4444);
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        assert_reset();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hDEAD;
        @(negedge clk);
        chk("late rvalid instr", bus.instr, 16'h0000);
        chk("restart addr", bus.mem_addr, RESET_PC);
        fetch(16'h5A5A, 1);

        // Randomised instruction stream against the model
        for (int k = 0; k < 40; k++) begin
            r_alu = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            exec(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r_alu,
                 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
            fetch(16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
